monitor_sys: RTL and testbench

//  SPI-slave control hub between the host MCU and the emulated core. Decodes host SPI commands to
//  - set core config, overlay enable, ROM-loading state and text cursor;
//  - write overlay text and stream ROM bytes to the core.

---
 rtl/monitor_pkg.sv | 26 ++
 rtl/monitor_sys_text_ram.sv | 21 ++
 rtl/monitor_sys.sv | 186 ++++++++++++++++++
 tb/tb_monitor_sys.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/monitor_pkg.sv
// monitor_pkg: command codes, text geometry, colours, decoder states and config-string helpers for monitor_sys.
package monitor_pkg;
  localparam int TEXT_COLS = 32;
  localparam int TEXT_ROWS = 28;
  localparam logic [7:0] CMD_READ_CFG = 8'd1;
  localparam logic [7:0] CMD_SET_CFG  = 8'd2;
  localparam logic [7:0] CMD_OVERLAY  = 8'd3;
  localparam logic [7:0] CMD_CURSOR   = 8'd4;
  localparam logic [7:0] CMD_TEXT     = 8'd5;
  localparam logic [7:0] CMD_ROM_EN   = 8'd6;
  localparam logic [7:0] CMD_ROM_LOAD = 8'd7;
  localparam logic [7:0] CMD_JOY      = 8'd8;
  localparam logic [14:0] COLOR_FG = 15'h7FFF;
  localparam logic [14:0] COLOR_BG = 15'h0000;
  typedef enum logic [3:0] {
    S_IDLE, S_CFG_RD, S_CFG_WR, S_OVL, S_CURSOR, S_TEXT,
    S_ROM_EN, S_ROM_LEN, S_ROM_DATA, S_JOY, S_SKIP
  } state_t;
  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? 8'h30 + {4'b0, v} : 8'h37 + {4'b0, v};
  endfunction
  function automatic logic [7:0] cfg_byte(input logic [2:0] i, input logic [3:0] id);
    return i == 3'd0 ? 8'h43 : i == 3'd1 ? 8'h4F : i == 3'd2 ? 8'h52 :
           i == 3'd3 ? 8'h45 : i == 3'd4 ? hex_char(id) : 8'h00;
  endfunction
endpackage

// File: rtl/monitor_sys_text_ram.sv
// text_ram: 32x28 byte overlay text buffer, one write port and one registered read port (rows >= 28 read 0).
module text_ram
  import monitor_pkg::*;
(
  input  logic       clk,
  input  logic       i_we,
  input  logic [4:0] i_x_wr,
  input  logic [4:0] i_y_wr,
  input  logic [7:0] i_char_wr,
  input  logic [4:0] i_rd_x,
  input  logic [4:0] i_rd_y,
  output logic [7:0] o_rd_data
);
  logic [7:0] r_mem [TEXT_COLS*TEXT_ROWS];
  logic [7:0] r_rd;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[{i_y_wr, i_x_wr}] <= i_char_wr;
    r_rd <= (i_rd_y < 5'(TEXT_ROWS)) ? r_mem[{i_rd_y, i_rd_x}] : 8'h00;
  end
  assign o_rd_data = r_rd;
endmodule

// File: rtl/monitor_sys.sv
// monitor_sys: SPI-slave command decoder, overlay text buffer/renderer and ROM byte streamer.
// Define JOYPAD_READ_EN to make CMD8 return both joypad words over miso.
module monitor_sys
  import monitor_pkg::*;
#(
  parameter int FREQ    = 21_477_000,
  parameter int CORE_ID = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        overlay,
  input  logic [7:0]  overlay_x,
  input  logic [7:0]  overlay_y,
  output logic [14:0] overlay_color,
  input  logic [11:0] joy1,
  input  logic [11:0] joy2,
  output logic        rom_loading,
  output logic [7:0]  rom_do,
  output logic        rom_do_valid,
  output logic [31:0] core_config,
  input  logic        sspi_cs,
  input  logic        sspi_clk,
  input  logic        sspi_mosi,
  output logic        sspi_miso
);
  logic [2:0]  r_cs_s, r_sck_s;
  logic [1:0]  r_mosi_s;
  logic [2:0]  r_bit_cnt, r_idx;
  logic [7:0]  r_shift, r_tx;
  state_t      r_state, w_next, w_cmd_state, w_joy_state;
  logic [23:0] r_cfg_sh, r_rom_remain;
  logic [31:0] r_core_config;
  logic        r_overlay, r_rom_loading, r_rom_do_valid, r_we, r_in_range;
  logic [7:0]  r_cursor_x, r_cursor_y, r_x_wr, r_y_wr, r_char_wr, r_rom_do;
  logic [7:0]  w_byte, w_tx_next, w_cell, w_joy_byte;
  logic [2:0]  w_sel;
  logic        w_sck_rise, w_rx, w_cs_high, w_byte_vld, w_cfg_rd, w_joy_rd, w_unused;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_s   <= 3'b111;
      r_sck_s  <= 3'b000;
      r_mosi_s <= 2'b00;
    end else begin
      r_cs_s   <= {r_cs_s[1:0], sspi_cs};
      r_sck_s  <= {r_sck_s[1:0], sspi_clk};
      r_mosi_s <= {r_mosi_s[0], sspi_mosi};
    end
  end
  // cs is judged one stage later than sclk so a byte finishing as cs rises is still taken
  assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
  assign w_rx       = w_sck_rise & ~r_cs_s[2];
  assign w_cs_high  = r_cs_s[1];
  assign w_byte_vld = w_rx & (r_bit_cnt == 3'd7);
  assign w_byte     = {r_shift[6:0], r_mosi_s[1]};
  assign w_sel      = (r_state == S_IDLE) ? 3'd0 : r_idx + 3'd1;
  assign w_cfg_rd   = (r_state == S_IDLE) ? (w_byte == CMD_READ_CFG) : (r_state == S_CFG_RD);
`ifdef JOYPAD_READ_EN
  assign w_joy_state = (w_byte == CMD_JOY) ? S_JOY : S_SKIP;
  assign w_joy_rd    = (r_state == S_IDLE) ? (w_byte == CMD_JOY) : (r_state == S_JOY);
  assign w_joy_byte  = w_sel == 3'd0 ? {4'b0, joy1[11:8]} : w_sel == 3'd1 ? joy1[7:0] :
                       w_sel == 3'd2 ? {4'b0, joy2[11:8]} : w_sel == 3'd3 ? joy2[7:0] : 8'h00;
  assign w_unused    = ^{FREQ[0], r_x_wr[7:5], r_y_wr[7:5]};
`else
  assign w_joy_state = S_SKIP;
  assign w_joy_rd    = 1'b0;
  assign w_joy_byte  = 8'h00;
  assign w_unused    = ^{FREQ[0], r_x_wr[7:5], r_y_wr[7:5], joy1, joy2};
`endif
  assign w_tx_next = w_cfg_rd ? cfg_byte(w_sel, 4'(CORE_ID)) : w_joy_rd ? w_joy_byte : 8'h00;
  assign w_cmd_state = w_byte == CMD_READ_CFG ? S_CFG_RD : w_byte == CMD_SET_CFG ? S_CFG_WR :
                       w_byte == CMD_OVERLAY ? S_OVL : w_byte == CMD_CURSOR ? S_CURSOR :
                       w_byte == CMD_TEXT ? S_TEXT : w_byte == CMD_ROM_EN ? S_ROM_EN :
                       w_byte == CMD_ROM_LOAD ? S_ROM_LEN : w_joy_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 8'h00;
    end else begin
      if (w_rx) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_byte;
        r_tx      <= w_byte_vld ? w_tx_next : {r_tx[6:0], 1'b0};
      end
      if (w_cs_high) begin
        r_bit_cnt <= 3'd0;
        r_tx      <= 8'h00;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (w_byte_vld) begin
      case (r_state)
        S_IDLE:     w_next = w_cmd_state;
        S_CFG_WR:   w_next = (r_idx == 3'd3) ? S_IDLE : r_state;
        S_OVL:      w_next = S_IDLE;
        S_CURSOR:   w_next = (r_idx == 3'd1) ? S_IDLE : r_state;
        S_TEXT:     w_next = (w_byte == 8'h00) ? S_IDLE : r_state;
        S_ROM_EN:   w_next = S_IDLE;
        S_ROM_LEN:  w_next = (r_idx != 3'd2) ? r_state :
                             ({r_rom_remain[15:0], w_byte} == 24'd0) ? S_IDLE : S_ROM_DATA;
        S_ROM_DATA: w_next = (r_rom_remain == 24'd1) ? S_IDLE : r_state;
        default:    w_next = r_state;
      endcase
    end
    if (w_cs_high) w_next = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx          <= 3'd0;
      r_cfg_sh       <= 24'd0;
      r_core_config  <= 32'd0;
      r_overlay      <= 1'b0;
      r_cursor_x     <= 8'd0;
      r_cursor_y     <= 8'd0;
      r_x_wr         <= 8'd0;
      r_y_wr         <= 8'd0;
      r_char_wr      <= 8'd0;
      r_we           <= 1'b0;
      r_rom_loading  <= 1'b0;
      r_rom_remain   <= 24'd0;
      r_rom_do       <= 8'd0;
      r_rom_do_valid <= 1'b0;
    end else begin
      r_we           <= 1'b0;
      r_rom_do_valid <= 1'b0;
      if (w_byte_vld) begin
        r_idx <= (r_state == S_IDLE) ? 3'd0 : (r_idx == 3'd6) ? 3'd6 : r_idx + 3'd1;
        case (r_state)
          S_CFG_WR: begin
            r_cfg_sh <= {r_cfg_sh[15:0], w_byte};
            if (r_idx == 3'd3) r_core_config <= {r_cfg_sh, w_byte};
          end
          S_OVL: r_overlay <= w_byte[0];
          S_CURSOR: begin
            if (r_idx == 3'd0) r_cursor_x <= w_byte;
            else r_cursor_y <= w_byte;
          end
          S_TEXT: begin
            if (w_byte != 8'h00) begin
              r_x_wr     <= r_cursor_x;
              r_y_wr     <= r_cursor_y;
              r_char_wr  <= w_byte;
              r_we       <= (r_cursor_x < 8'(TEXT_COLS)) && (r_cursor_y < 8'(TEXT_ROWS));
              r_cursor_x <= r_cursor_x + 8'd1;
            end
          end
          S_ROM_EN:  r_rom_loading <= w_byte[0];
          S_ROM_LEN: r_rom_remain <= {r_rom_remain[15:0], w_byte};
          S_ROM_DATA: begin
            r_rom_do       <= w_byte;
            r_rom_do_valid <= 1'b1;
            r_rom_remain   <= r_rom_remain - 24'd1;
          end
          default: ;
        endcase
      end
    end
  end
  text_ram u_text_ram (
    .clk       (clk),
    .i_we      (r_we),
    .i_x_wr    (r_x_wr[4:0]),
    .i_y_wr    (r_y_wr[4:0]),
    .i_char_wr (r_char_wr),
    .i_rd_x    (overlay_x[7:3]),
    .i_rd_y    (overlay_y[7:3]),
    .o_rd_data (w_cell)
  );
  always_ff @(posedge clk) begin
    if (reset) r_in_range <= 1'b0;
    else r_in_range <= overlay_y[7:3] < 5'(TEXT_ROWS);
  end
  assign overlay_color = (r_in_range && w_cell != 8'h00 && w_cell != 8'h20) ? COLOR_FG : COLOR_BG;
  assign overlay       = r_overlay;
  assign rom_loading   = r_rom_loading;
  assign rom_do        = r_rom_do;
  assign rom_do_valid  = r_rom_do_valid;
  assign core_config   = r_core_config;
  assign sspi_miso     = r_tx[7];
endmodule

// File: tb/tb_monitor_sys.sv
// tb_monitor_sys: directed SPI command tests for monitor_sys with hand-computed expectations.
module tb_monitor_sys;
  import monitor_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic overlay, rom_loading, rom_do_valid, sspi_miso;
  logic [7:0] overlay_x = 8'd0, overlay_y = 8'd0, rom_do;
  logic [14:0] overlay_color;
  logic [11:0] joy1 = 12'hABC, joy2 = 12'h123;
  logic [31:0] core_config;
  logic sspi_cs = 1'b1, sspi_clk = 1'b0, sspi_mosi = 1'b0;
  int checks = 0, failures = 0;
  int we_cnt = 0, rom_cnt = 0;
  logic [7:0] lw_x, lw_y, lw_c;
  logic [7:0] rom_bytes [16];

  monitor_sys #(.FREQ(21_477_000), .CORE_ID(1)) dut (
    .clk(clk), .reset(reset), .overlay(overlay), .overlay_x(overlay_x), .overlay_y(overlay_y),
    .overlay_color(overlay_color), .joy1(joy1), .joy2(joy2), .rom_loading(rom_loading),
    .rom_do(rom_do), .rom_do_valid(rom_do_valid), .core_config(core_config),
    .sspi_cs(sspi_cs), .sspi_clk(sspi_clk), .sspi_mosi(sspi_mosi), .sspi_miso(sspi_miso)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.r_we) begin
      we_cnt++;
      lw_x = dut.r_x_wr;
      lw_y = dut.r_y_wr;
      lw_c = dut.r_char_wr;
    end
    if (rom_do_valid) begin
      if (rom_cnt < 16) rom_bytes[rom_cnt] = rom_do;
      rom_cnt++;
    end
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, input bit cs_at_last_rise = 0);
    for (int i = 7; i >= 0; i--) begin
      sspi_mosi = tx[i];
      #50;
      rx[i] = sspi_miso;
      sspi_clk = 1'b1;
      if (i == 0 && cs_at_last_rise) begin
        #1 sspi_cs = 1'b1;
        #49;
      end else #50;
      sspi_clk = 1'b0;
    end
    #20;
  endtask

  task automatic cs_low();
    sspi_cs = 1'b0;
    #60;
  endtask

  task automatic cs_high();
    #30;
    sspi_cs = 1'b1;
    #100;
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx;
    xfer(b, rx);
  endtask

  task automatic set_cursor(input logic [7:0] x, input logic [7:0] y);
    cs_low(); send(CMD_CURSOR); send(x); send(y); cs_high();
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checks++; if (overlay !== 1'b0) begin failures++; $display("FAIL reset_overlay got=%b exp=0", overlay); end
    checks++; if (rom_loading !== 1'b0) begin failures++; $display("FAIL reset_rom_loading got=%b exp=0", rom_loading); end
    checks++; if (rom_do_valid !== 1'b0 || rom_do !== 8'h00) begin failures++; $display("FAIL reset_rom_do got=%b/%h exp=0/00", rom_do_valid, rom_do); end
    checks++; if (core_config !== 32'h0) begin failures++; $display("FAIL reset_core_config got=%h exp=0", core_config); end
    checks++; if (sspi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", sspi_miso); end
    checks++; if (overlay_color !== 15'h0) begin failures++; $display("FAIL reset_color got=%h exp=0", overlay_color); end
    checks++; if (dut.r_cursor_x !== 8'h0 || dut.r_cursor_y !== 8'h0) begin failures++; $display("FAIL reset_cursor got=%h,%h exp=00,00", dut.r_cursor_x, dut.r_cursor_y); end
    checks++; if (dut.r_rom_remain !== 24'h0) begin failures++; $display("FAIL reset_rom_remain got=%h exp=0", dut.r_rom_remain); end
    checks++; if (dut.r_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, S_IDLE); end
  endtask

  task automatic test_cfg_read();
    logic [7:0] rx, exp;
    logic [7:0] str [5];
    str[0] = 8'h43; str[1] = 8'h4F; str[2] = 8'h52; str[3] = 8'h45; str[4] = 8'h31;
    cs_low();
    send(CMD_READ_CFG);
    for (int i = 0; i < 64; i++) begin
      xfer(8'h00, rx);
      exp = (i < 5) ? str[i] : 8'h00;
      checks++; if (rx !== exp) begin failures++; $display("FAIL cfg_read byte%0d got=%h exp=%h", i, rx, exp); end
    end
    cs_high();
    checks++; if (sspi_miso !== 1'b0) begin failures++; $display("FAIL cfg_miso_idle got=%b exp=0", sspi_miso); end
  endtask

  task automatic test_set_config();
    cs_low(); send(CMD_SET_CFG); send(8'hA5); send(8'hA5); send(8'hA5); send(8'hA5); cs_high();
    checks++; if (core_config !== 32'hA5A5A5A5) begin failures++; $display("FAIL config_a5 got=%h exp=A5A5A5A5", core_config); end
    cs_low(); send(CMD_SET_CFG); send(8'h12); send(8'h34); send(8'h56);
    checks++; if (core_config !== 32'hA5A5A5A5) begin failures++; $display("FAIL config_partial got=%h exp=A5A5A5A5", core_config); end
    send(8'h78); cs_high();
    checks++; if (core_config !== 32'h12345678) begin failures++; $display("FAIL config_order got=%h exp=12345678", core_config); end
  endtask

  task automatic test_overlay();
    cs_low(); send(CMD_OVERLAY); send(8'h01); cs_high();
    checks++; if (overlay !== 1'b1) begin failures++; $display("FAIL overlay_on got=%b exp=1", overlay); end
    cs_low(); send(CMD_OVERLAY); send(8'h02); cs_high();
    checks++; if (overlay !== 1'b0) begin failures++; $display("FAIL overlay_bit0 got=%b exp=0", overlay); end
  endtask

  task automatic test_cs_edge();
    logic [7:0] rx;
    cs_low(); send(CMD_OVERLAY); xfer(8'h01, rx, 1); #100;
    checks++; if (overlay !== 1'b1) begin failures++; $display("FAIL cs_same_cycle got=%b exp=1", overlay); end
    cs_low();
    for (int i = 0; i < 3; i++) begin
      sspi_mosi = 1'b1; #50; sspi_clk = 1'b1; #50; sspi_clk = 1'b0;
    end
    cs_high();
    cs_low(); send(CMD_OVERLAY); send(8'h00); cs_high();
    checks++; if (overlay !== 1'b0) begin failures++; $display("FAIL cs_abort_realign got=%b exp=0", overlay); end
  endtask

  task automatic test_cursor();
    set_cursor(8'h12, 8'h03);
    checks++; if (dut.r_cursor_x !== 8'h12 || dut.r_cursor_y !== 8'h03) begin failures++; $display("FAIL cursor got=%h,%h exp=12,03", dut.r_cursor_x, dut.r_cursor_y); end
  endtask

  task automatic test_text();
    set_cursor(8'h00, 8'h00);
    we_cnt = 0;
    cs_low(); send(CMD_TEXT); send(8'h41);
    checks++; if (we_cnt !== 1 || lw_x !== 8'h00 || lw_y !== 8'h00 || lw_c !== 8'h41) begin failures++; $display("FAIL text_A got=we%0d x%h y%h c%h exp=we1 x00 y00 c41", we_cnt, lw_x, lw_y, lw_c); end
    send(8'h42);
    checks++; if (we_cnt !== 2 || lw_x !== 8'h01 || lw_c !== 8'h42) begin failures++; $display("FAIL text_B got=we%0d x%h c%h exp=we2 x01 c42", we_cnt, lw_x, lw_c); end
    cs_high();
    checks++; if (dut.r_cursor_x !== 8'h02) begin failures++; $display("FAIL text_cursor got=%h exp=02", dut.r_cursor_x); end
    set_cursor(8'h1F, 8'h00);
    cs_low(); send(CMD_TEXT); send(8'h43);
    checks++; if (we_cnt !== 3 || lw_x !== 8'h1F) begin failures++; $display("FAIL text_C got=we%0d x%h exp=we3 x1F", we_cnt, lw_x); end
    send(8'h44);
    checks++; if (we_cnt !== 3 || dut.r_x_wr !== 8'h20) begin failures++; $display("FAIL text_D_drop got=we%0d x%h exp=we3 x20", we_cnt, dut.r_x_wr); end
    send(8'h00);
    checks++; if (we_cnt !== 3 || dut.r_state !== S_IDLE) begin failures++; $display("FAIL text_term got=we%0d st%0d exp=we3 st%0d", we_cnt, dut.r_state, S_IDLE); end
    cs_high();
    set_cursor(8'h00, 8'd28);
    cs_low(); send(CMD_TEXT); send(8'h5A); cs_high();
    checks++; if (we_cnt !== 3) begin failures++; $display("FAIL text_row28_drop got=we%0d exp=we3", we_cnt); end
    set_cursor(8'h05, 8'h01);
    cs_low(); send(CMD_TEXT); send(8'h20); cs_high();
    checks++; if (we_cnt !== 4 || lw_c !== 8'h20) begin failures++; $display("FAIL text_space got=we%0d c%h exp=we4 c20", we_cnt, lw_c); end
  endtask

  task automatic test_render();
    logic [7:0] xs [5];
    logic [7:0] ys [5];
    logic [14:0] es [5];
    xs[0] = 8'd0;   ys[0] = 8'd0;   es[0] = 15'h7FFF;
    xs[1] = 8'd15;  ys[1] = 8'd7;   es[1] = 15'h7FFF;
    xs[2] = 8'd252; ys[2] = 8'd3;   es[2] = 15'h7FFF;
    xs[3] = 8'd42;  ys[3] = 8'd9;   es[3] = 15'h0000;
    xs[4] = 8'd0;   ys[4] = 8'd224; es[4] = 15'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); overlay_x = xs[i]; overlay_y = ys[i];
      @(negedge clk);
      checks++; if (overlay_color !== es[i]) begin failures++; $display("FAIL render%0d x=%0d y=%0d got=%h exp=%h", i, xs[i], ys[i], overlay_color, es[i]); end
    end
  endtask

  task automatic test_rom_loading();
    cs_low(); send(CMD_ROM_EN); send(8'h01); cs_high();
    checks++; if (rom_loading !== 1'b1) begin failures++; $display("FAIL rom_loading_on got=%b exp=1", rom_loading); end
    cs_low(); send(CMD_ROM_EN); send(8'h00); cs_high();
    checks++; if (rom_loading !== 1'b0) begin failures++; $display("FAIL rom_loading_off got=%b exp=0", rom_loading); end
  endtask

  task automatic test_rom_stream();
    rom_cnt = 0;
    cs_low(); send(CMD_ROM_LOAD); send(8'h00); send(8'h00); send(8'h03);
    checks++; if (dut.r_rom_remain !== 24'd3) begin failures++; $display("FAIL rom_len got=%h exp=000003", dut.r_rom_remain); end
    send(8'h11); send(8'h22); send(8'h33);
    checks++; if (rom_cnt !== 3) begin failures++; $display("FAIL rom_pulses got=%0d exp=3", rom_cnt); end
    checks++; if (rom_bytes[0] !== 8'h11 || rom_bytes[1] !== 8'h22 || rom_bytes[2] !== 8'h33) begin failures++; $display("FAIL rom_bytes got=%h %h %h exp=11 22 33", rom_bytes[0], rom_bytes[1], rom_bytes[2]); end
    checks++; if (dut.r_rom_remain !== 24'd0 || dut.r_state !== S_IDLE) begin failures++; $display("FAIL rom_done got=%h st%0d exp=0 st%0d", dut.r_rom_remain, dut.r_state, S_IDLE); end
    send(8'h44);
    cs_high();
    checks++; if (rom_cnt !== 3) begin failures++; $display("FAIL rom_extra got=%0d exp=3", rom_cnt); end
    cs_low(); send(CMD_ROM_LOAD); send(8'h00); send(8'h00); send(8'h00);
    checks++; if (dut.r_state !== S_IDLE) begin failures++; $display("FAIL rom_len0 got=st%0d exp=st%0d", dut.r_state, S_IDLE); end
    send(8'h55);
    cs_high();
    checks++; if (rom_cnt !== 3) begin failures++; $display("FAIL rom_len0_data got=%0d exp=3", rom_cnt); end
  endtask

  task automatic test_unknown();
    logic [7:0] rx;
    cs_low(); send(8'h55); send(CMD_SET_CFG); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); cs_high();
    checks++; if (core_config !== 32'h12345678) begin failures++; $display("FAIL unknown_ignored got=%h exp=12345678", core_config); end
`ifdef JOYPAD_READ_EN
    begin
      logic [7:0] ej [4];
      ej[0] = 8'h0A; ej[1] = 8'hBC; ej[2] = 8'h01; ej[3] = 8'h23;
      cs_low(); send(CMD_JOY);
      for (int i = 0; i < 4; i++) begin
        xfer(8'h00, rx);
        checks++; if (rx !== ej[i]) begin failures++; $display("FAIL joy_byte%0d got=%h exp=%h", i, rx, ej[i]); end
      end
      cs_high();
    end
`else
    cs_low(); send(CMD_JOY); xfer(8'h00, rx);
    checks++; if (rx !== 8'h00 || dut.r_state !== S_SKIP) begin failures++; $display("FAIL cmd8_unknown got=%h st%0d exp=00 st%0d", rx, dut.r_state, S_SKIP); end
    cs_high();
`endif
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cfg_read();
    test_set_config();
    test_overlay();
    test_cs_edge();
    test_cursor();
    test_text();
    test_render();
    test_rom_loading();
    test_rom_stream();
    test_unknown();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
